periferico_es: RTL and testbench
================================

PERIFERICO_ES -- requirements
Module: periferico_es

Interface
REQ-001 Parameter: BASE, 16'h0000, I/O base address; block decodes dir[15:3] == BASE[15:3], offset = dir[2:0].
REQ-002 Port: clk  input  1  single clock, all state on rising edge.
REQ-003 Port: reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-004 Port: enable  input  1  I/O access strobe from CPU (enable_wishbone).
REQ-005 Port: rd  input  1  read qualifier.
REQ-006 Port: wr  input  1  write qualifier.
REQ-007 Port: dir  input  16  I/O address.
REQ-008 Port: datoEntrada  input  8  write data from CPU.
REQ-009 Port: datoSalida  output  8  read data to CPU.
REQ-010 Port: entradaExterna  input  8  asynchronous external input pins.
REQ-011 Port: salidaExterna  output  8  external output pins.
REQ-012 Port: interrupciones  output  3  interrupt code to CPU; 3'b000 = none.

Function
REQ-013 Hit = enable && dir[15:3]==BASE[15:3]; write occurs at clk edge when hit && wr; read is combinational when hit && rd && !wr.
REQ-014 datoSalida SHALL be 8'h00 whenever not a read hit; same-cycle combinational data when a read hit.
REQ-015 Map: 0 SALIDA RW -> salidaExterna; 1 ENTRADA RO (synchronized input); 2 RECARGA RW; 3 CTRL RW; 4 ESTADO R / write-1-to-clear; 5 CUENTA RO; 6,7 read 8'h00, writes ignored.
REQ-016 CTRL bits: [0] timer run, [1] timer irq enable, [2] auto-reload, [3] input-change irq enable, [7:4] read 0.
REQ-017 ESTADO bits: [0] timer pending, [1] input-change pending, [7:2] read 0.
REQ-018 entradaExterna SHALL pass a 2-flop synchronizer; ENTRADA reads second stage; latency 2 cycles.
REQ-019 Input-change pending SHALL set when second stage differs from a third (previous-value) stage, regardless of CTRL[3].
REQ-020 Timer: each cycle with CTRL[0]=1: if CUENTA==0 then set timer pending and CUENTA<=RECARGA, and clear CTRL[0] if CTRL[2]=0; else CUENTA<=CUENTA-1; period = RECARGA+1 cycles.
REQ-021 Write to RECARGA SHALL also load CUENTA with the written value in the same edge.
REQ-022 Pending set and write-1-to-clear on same bit in same cycle: set wins.
REQ-023 Interrupt issue: a source whose pending bit rises 0->1 with its enable set becomes queued; interrupciones SHALL carry exactly one code for exactly one cycle per queued event, registered output.
REQ-024 Codes: timer 3'b001, input-change 3'b010; timer has priority; the loser stays queued and issues the next cycle.
REQ-025 A source SHALL not re-issue until its pending bit is cleared and set again; clearing pending also drops any queued, unissued event of that source.

Reset
REQ-026 On reset: SALIDA, RECARGA, CTRL, ESTADO, CUENTA, synchronizer stages, queue = 0; interrupciones = 3'b000; salidaExterna = 8'h00.
REQ-027 Reset mid-count or mid-queue SHALL discard all pending/queued events; no interrupt pulse after release without new event.

Configuration
REQ-028 Macro PERIFERICO_ES_TIMER_EN: defined -> timer per REQ-020/021/024 present.
REQ-029 Undefined -> no timer logic; RECARGA, CUENTA, CTRL[2:0], ESTADO[0] read 0, writes to them ignored, code 3'b001 never issued.

Verification
REQ-030 Reset, write 8'hA5 to BASE+0 -> salidaExterna=8'hA5 next cycle; read BASE+0 -> datoSalida=8'hA5 same cycle; read BASE+6 -> 8'h00.
REQ-031 entradaExterna 8'h00->8'h3C -> ENTRADA=8'h3C after 2 cycles, ESTADO[1]=1; with CTRL=8'h08, interrupciones=3'b010 for exactly one cycle.
REQ-032 RECARGA=8'h03, CTRL=8'h07 -> ESTADO[0] sets every 4 cycles; one 3'b001 pulse, no second pulse until write 8'h01 to BASE+4.
REQ-033 Timer expiry and input change same cycle with CTRL=8'h0B -> 3'b001 then 3'b010 on consecutive cycles.
REQ-034 Assert reset while CUENTA=8'h02 and queue non-empty -> all registers 0, interrupciones stays 3'b000 after release.

Source files
------------

// File: rtl/periferico_es.sv
// Memory-mapped I/O peripheral: output latch, synchronized input with change detect,
// optional down-counting timer (enabled by defining PERIFERICO_ES_TIMER_EN), coded interrupts.
module periferico_es #(
  parameter logic [15:0] BASE = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        rd,
  input  logic        wr,
  input  logic [15:0] dir,
  input  logic [7:0]  datoEntrada,
  output logic [7:0]  datoSalida,
  input  logic [7:0]  entradaExterna,
  output logic [7:0]  salidaExterna,
  output logic [2:0]  interrupciones
);

  localparam logic [2:0] OFS_SALIDA  = 3'd0;
  localparam logic [2:0] OFS_ENTRADA = 3'd1;
  localparam logic [2:0] OFS_RECARGA = 3'd2;
  localparam logic [2:0] OFS_CTRL    = 3'd3;
  localparam logic [2:0] OFS_ESTADO  = 3'd4;
  localparam logic [2:0] OFS_CUENTA  = 3'd5;

  // Bus access: enable qualifies dir; wr commits on the clock edge, rd without wr
  // returns data combinationally in the same cycle. There is no wait state.
  logic       hit;
  logic       writeHit;
  logic       readHit;
  logic [2:0] offset;

  assign hit      = enable && (dir[15:3] == BASE[15:3]);
  assign writeHit = hit && wr;
  assign readHit  = hit && rd && !wr;
  assign offset   = dir[2:0];

  logic [7:0] salida;
  logic [7:0] sync1;
  logic [7:0] sync2;
  logic [7:0] sync3;
  logic       ctrlIn;
  logic [1:0] estado;
  logic [1:0] estadoNext;
  logic [1:0] queue;
  logic [1:0] queueNext;
  logic [1:0] rise;
  logic [1:0] issue;
  logic [1:0] w1c;
  logic [2:0] irqReg;
  logic [2:0] irqNext;
  logic       inputSet;

  logic       timerSet;
  logic [7:0] recargaRd;
  logic [7:0] cuentaRd;
  logic [2:0] ctrlTimer;

  assign inputSet = (sync2 != sync3);

`ifdef PERIFERICO_ES_TIMER_EN
  logic [7:0] recarga;
  logic [7:0] cuenta;
  logic [2:0] ctrlT;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      recarga <= 8'h00;
      cuenta  <= 8'h00;
      ctrlT   <= 3'b000;
    end else begin
      // A RECARGA write restarts the count even while the timer runs.
      if (writeHit && offset == OFS_RECARGA) begin
        recarga <= datoEntrada;
        cuenta  <= datoEntrada;
      end else if (ctrlT[0]) begin
        cuenta <= (cuenta == 8'h00) ? recarga : cuenta - 8'd1;
      end
      if (writeHit && offset == OFS_CTRL) begin
        ctrlT <= datoEntrada[2:0];
      end else if (ctrlT[0] && cuenta == 8'h00 && !ctrlT[2]) begin
        ctrlT[0] <= 1'b0;
      end
    end
  end

  assign timerSet  = ctrlT[0] && (cuenta == 8'h00);
  assign recargaRd = recarga;
  assign cuentaRd  = cuenta;
  assign ctrlTimer = ctrlT;
`else
  assign timerSet  = 1'b0;
  assign recargaRd = 8'h00;
  assign cuentaRd  = 8'h00;
  assign ctrlTimer = 3'b000;
`endif

  // Bit 0 = timer, bit 1 = input change. A queued event lives only while its pending bit does.
  always_comb begin
    w1c        = (writeHit && offset == OFS_ESTADO) ? datoEntrada[1:0] : 2'b00;
    estadoNext = (estado & ~w1c) | {inputSet, timerSet};
    rise       = estadoNext & ~estado & {ctrlIn, ctrlTimer[1]};
    issue[0]   = queue[0] && estadoNext[0];
    issue[1]   = queue[1] && estadoNext[1] && !issue[0];
    queueNext  = ((queue & ~issue) | rise) & estadoNext;
    irqNext    = 3'b000;
    if (issue[0]) begin
      irqNext = 3'b001;
    end else if (issue[1]) begin
      irqNext = 3'b010;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      salida <= 8'h00;
      ctrlIn <= 1'b0;
      sync1  <= 8'h00;
      sync2  <= 8'h00;
      sync3  <= 8'h00;
      estado <= 2'b00;
      queue  <= 2'b00;
      irqReg <= 3'b000;
    end else begin
      sync1  <= entradaExterna;
      sync2  <= sync1;
      sync3  <= sync2;
      estado <= estadoNext;
      queue  <= queueNext;
      irqReg <= irqNext;
      if (writeHit && offset == OFS_SALIDA) salida <= datoEntrada;
      if (writeHit && offset == OFS_CTRL) ctrlIn <= datoEntrada[3];
    end
  end

  always_comb begin
    datoSalida = 8'h00;
    if (readHit) begin
      case (offset)
        OFS_SALIDA:  datoSalida = salida;
        OFS_ENTRADA: datoSalida = sync2;
        OFS_RECARGA: datoSalida = recargaRd;
        OFS_CTRL:    datoSalida = {4'h0, ctrlIn, ctrlTimer};
        OFS_ESTADO:  datoSalida = {6'h00, estado};
        OFS_CUENTA:  datoSalida = cuentaRd;
        default:     datoSalida = 8'h00;
      endcase
    end
  end

  assign salidaExterna  = salida;
  assign interrupciones = irqReg;

endmodule

// File: tb/tb_periferico_es.sv
// Self-checking bench for periferico_es; timer scenarios compile in when
// PERIFERICO_ES_TIMER_EN is defined, otherwise the timer-absent behaviour is checked.
module tb_periferico_es;

  localparam logic [15:0] BASE = 16'h0120;

`ifdef PERIFERICO_ES_TIMER_EN
  localparam bit TIMER = 1'b1;
`else
  localparam bit TIMER = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        rd;
  logic        wr;
  logic [15:0] dir;
  logic [7:0]  datoEntrada;
  logic [7:0]  datoSalida;
  logic [7:0]  entradaExterna;
  logic [7:0]  salidaExterna;
  logic [2:0]  interrupciones;

  int checks = 0;
  int errors = 0;
  logic [2:0] exp_q[$];
  logic [2:0] prevIrq = 3'b000;
  logic [2:0] monExp;
  logic [7:0] rdata;

  periferico_es #(.BASE(BASE)) dut (
    .clk(clk),
    .reset(reset),
    .enable(enable),
    .rd(rd),
    .wr(wr),
    .dir(dir),
    .datoEntrada(datoEntrada),
    .datoSalida(datoSalida),
    .entradaExterna(entradaExterna),
    .salidaExterna(salidaExterna),
    .interrupciones(interrupciones)
  );

  always #5 clk = ~clk;

  // Interrupt scoreboard: each non-zero code must match the oldest expected one.
  always @(negedge clk) begin
    if (reset === 1'b1) begin
      prevIrq = 3'b000;
    end else begin
      if (interrupciones !== 3'b000) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL irq_unexpected: got %b, expected none", interrupciones);
        end else begin
          monExp = exp_q.pop_front();
          if (interrupciones !== monExp) begin
            errors++;
            $display("FAIL irq_code: got %b, expected %b", interrupciones, monExp);
          end
        end
        if (prevIrq === interrupciones) begin
          errors++;
          $display("FAIL irq_width: code %b held for more than one cycle", interrupciones);
        end
      end
      prevIrq = interrupciones;
    end
  end

  task automatic cpuWrite(input logic [2:0] off, input logic [7:0] data);
    @(negedge clk);
    enable = 1'b1; wr = 1'b1; rd = 1'b0;
    dir = BASE + {13'd0, off};
    datoEntrada = data;
    @(posedge clk);
    #1;
    enable = 1'b0; wr = 1'b0;
  endtask

  task automatic cpuRead(input logic [2:0] off, output logic [7:0] data);
    @(negedge clk);
    enable = 1'b1; rd = 1'b1; wr = 1'b0;
    dir = BASE + {13'd0, off};
    #1;
    data = datoSalida;
    #1;
    enable = 1'b0; rd = 1'b0;
  endtask

  task automatic expectRead(input logic [2:0] off, input logic [7:0] exp, input string name);
    logic [7:0] got;
    cpuRead(off, got);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  task automatic waitDrain(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL irq_missing: %0d expected codes never issued, next %b", exp_q.size(), exp_q[0]);
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b0; rd = 1'b0; wr = 1'b0;
    dir = 16'h0000; datoEntrada = 8'h00; entradaExterna = 8'h00;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    checks++;
    if (interrupciones !== 3'b000) begin
      errors++; $display("FAIL reset_irq: got %b, expected 000", interrupciones);
    end
    checks++;
    if (salidaExterna !== 8'h00) begin
      errors++; $display("FAIL reset_salida: got %h, expected 00", salidaExterna);
    end
    for (int i = 0; i < 8; i++) expectRead(i[2:0], 8'h00, "reset_reg");
  endtask

  task automatic test_salida();
    cpuWrite(3'd0, 8'hA5);
    checks++;
    if (salidaExterna !== 8'hA5) begin
      errors++; $display("FAIL salida_pin: got %h, expected a5", salidaExterna);
    end
    expectRead(3'd0, 8'hA5, "salida_read");
    expectRead(3'd6, 8'h00, "ofs6_read");
    cpuWrite(3'd7, 8'hFF);
    expectRead(3'd7, 8'h00, "ofs7_read");
    // Write to another 8-byte window must not land here.
    @(negedge clk);
    enable = 1'b1; wr = 1'b1; dir = BASE ^ 16'h0100; datoEntrada = 8'h5A;
    @(posedge clk);
    #1 enable = 1'b0; wr = 1'b0;
    checks++;
    if (salidaExterna !== 8'hA5) begin
      errors++; $display("FAIL decode_write: got %h, expected a5", salidaExterna);
    end
    @(negedge clk);
    enable = 1'b1; rd = 1'b1; wr = 1'b1; dir = BASE; datoEntrada = 8'hA5;
    #1;
    checks++;
    if (datoSalida !== 8'h00) begin
      errors++; $display("FAIL rd_wr_data: got %h, expected 00", datoSalida);
    end
    wr = 1'b0; dir = BASE ^ 16'h0100;
    #1;
    checks++;
    if (datoSalida !== 8'h00) begin
      errors++; $display("FAIL decode_read: got %h, expected 00", datoSalida);
    end
    enable = 1'b0; dir = BASE;
    #1;
    checks++;
    if (datoSalida !== 8'h00) begin
      errors++; $display("FAIL no_enable_read: got %h, expected 00", datoSalida);
    end
    rd = 1'b0;
  endtask

  task automatic test_config_regs();
    cpuWrite(3'd2, 8'h3C);
    expectRead(3'd2, TIMER ? 8'h3C : 8'h00, "recarga_read");
    expectRead(3'd5, TIMER ? 8'h3C : 8'h00, "cuenta_load");
    cpuWrite(3'd5, 8'h77);
    expectRead(3'd5, TIMER ? 8'h3C : 8'h00, "cuenta_ro");
    cpuWrite(3'd1, 8'hFF);
    expectRead(3'd1, 8'h00, "entrada_ro");
    cpuWrite(3'd3, 8'hF6);
    expectRead(3'd3, TIMER ? 8'h06 : 8'h00, "ctrl_mask");
    cpuWrite(3'd4, 8'hFF);
    expectRead(3'd4, 8'h00, "estado_idle");
`ifndef PERIFERICO_ES_TIMER_EN
    // With no timer, enabling every CTRL bit must never raise code 001.
    cpuWrite(3'd3, 8'h0F);
    expectRead(3'd3, 8'h08, "ctrl_no_timer");
    repeat (8) @(negedge clk);
    expectRead(3'd4, 8'h00, "estado_no_timer");
`endif
    cpuWrite(3'd3, 8'h00);
  endtask

  task automatic test_input_change();
    cpuWrite(3'd3, 8'h08);
    exp_q.push_back(3'b010);
    @(negedge clk);
    entradaExterna = 8'h3C;
    expectRead(3'd1, 8'h00, "entrada_lat1");
    expectRead(3'd1, 8'h3C, "entrada_lat2");
    expectRead(3'd4, 8'h02, "estado_input");
    @(negedge clk);
    checks++;
    if (interrupciones !== 3'b010) begin
      errors++; $display("FAIL input_irq: got %b, expected 010", interrupciones);
    end
    @(negedge clk);
    checks++;
    if (interrupciones !== 3'b000) begin
      errors++; $display("FAIL input_irq_end: got %b, expected 000", interrupciones);
    end
    waitDrain(4);
  endtask

  task automatic test_input_noirq();
    cpuWrite(3'd3, 8'h00);
    cpuWrite(3'd4, 8'h02);
    expectRead(3'd4, 8'h00, "estado_w1c");
    entradaExterna = 8'h0F;
    repeat (4) @(negedge clk);
    expectRead(3'd4, 8'h02, "estado_noirq");
    // Enabling after the fact is not a 0->1 rise, so nothing issues.
    cpuWrite(3'd3, 8'h08);
    repeat (4) @(negedge clk);
    cpuWrite(3'd4, 8'h02);
    expectRead(3'd4, 8'h00, "estado_clear2");
    cpuWrite(3'd3, 8'h00);
  endtask

`ifdef PERIFERICO_ES_TIMER_EN
  task automatic test_timer();
    cpuWrite(3'd3, 8'h00);
    cpuWrite(3'd4, 8'h03);
    cpuWrite(3'd2, 8'h03);
    exp_q.push_back(3'b001);
    cpuWrite(3'd3, 8'h07);
    for (int i = 0; i < 8; i++) expectRead(3'd5, 8'(3 - (i % 4)), "cuenta_seq");
    expectRead(3'd4, 8'h01, "estado_timer");
    exp_q.push_back(3'b001);
    cpuWrite(3'd4, 8'h01);
    expectRead(3'd4, 8'h00, "estado_timer_clr");
    expectRead(3'd3, 8'h07, "ctrl_autoreload");
    waitDrain(10);
    cpuWrite(3'd3, 8'h00);
    cpuWrite(3'd4, 8'h01);
    expectRead(3'd4, 8'h00, "estado_timer_stop");
    // One-shot: run bit drops after the first expiry.
    cpuWrite(3'd2, 8'h01);
    exp_q.push_back(3'b001);
    cpuWrite(3'd3, 8'h03);
    repeat (4) @(negedge clk);
    expectRead(3'd3, 8'h02, "ctrl_oneshot");
    expectRead(3'd5, 8'h01, "cuenta_oneshot");
    expectRead(3'd4, 8'h01, "estado_oneshot");
    waitDrain(4);
    cpuWrite(3'd4, 8'h01);
    cpuWrite(3'd3, 8'h00);
  endtask

  task automatic test_back_to_back();
    cpuWrite(3'd2, 8'h01);
    entradaExterna = 8'hC3;
    exp_q.push_back(3'b001);
    exp_q.push_back(3'b010);
    cpuWrite(3'd3, 8'h0B);
    repeat (4) @(negedge clk);
    checks++;
    if (interrupciones !== 3'b001) begin
      errors++; $display("FAIL b2b_first: got %b, expected 001", interrupciones);
    end
    @(negedge clk);
    checks++;
    if (interrupciones !== 3'b010) begin
      errors++; $display("FAIL b2b_second: got %b, expected 010", interrupciones);
    end
    waitDrain(4);
    expectRead(3'd4, 8'h03, "estado_both");
    expectRead(3'd3, 8'h0A, "ctrl_b2b");
    cpuWrite(3'd3, 8'h00);
    cpuWrite(3'd4, 8'h03);
  endtask
`endif

  task automatic test_reset_mid();
    cpuWrite(3'd0, 8'hA5);
    cpuWrite(3'd2, 8'h05);
    cpuWrite(3'd3, TIMER ? 8'h09 : 8'h08);
    entradaExterna = 8'h5A;
    repeat (3) @(posedge clk);
    expectRead(3'd5, TIMER ? 8'h02 : 8'h00, "cuenta_before_reset");
    reset = 1'b1;
    entradaExterna = 8'h00;
    #1;
    checks++;
    if (salidaExterna !== 8'h00) begin
      errors++; $display("FAIL async_reset: got %h, expected 00", salidaExterna);
    end
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    for (int i = 0; i < 6; i++) expectRead(i[2:0], 8'h00, "reg_after_reset");
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++;
      if (interrupciones !== 3'b000) begin
        errors++; $display("FAIL irq_after_reset: got %b, expected 000", interrupciones);
      end
    end
  endtask

  initial begin
    test_reset();
    test_salida();
    test_config_regs();
    test_input_change();
    test_input_noirq();
`ifdef PERIFERICO_ES_TIMER_EN
    test_timer();
    test_back_to_back();
`endif
    test_reset_mid();
    waitDrain(8);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
